// File: rtl/add_arb_ctrl.sv
// Two-requester arbiter/sequencer for the shared adder and 7-seg display.
// Define ADD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module add_arb_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned HOLD   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [3:0] adder_a,
    output logic [3:0] adder_b,
    input  logic [6:0] adder_seg,
    input  logic       adder_cout,
    output logic [6:0] disp_seg,
    output logic       disp_cout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_HOLD
    } state_e;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [6:0] seg_q, seg_d;
    logic       cout_q, cout_d;
    logic       win;
    logic [1:0] done_d;

`ifdef ADD_ARB_FIXED_PRIO_EN
    assign win = ~req[0];
`else
    logic last_q, last_d;

    // On a tie the requester that did not win last time is served.
    assign win = (req == 2'b11) ? ~last_q : req[1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        seg_d   = seg_q;
        cout_d  = cout_q;
        done_d  = 2'b00;
`ifndef ADD_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    cnt_d   = SETTLE_LD;
                    state_d = S_DRIVE;
`ifndef ADD_ARB_FIXED_PRIO_EN
                    last_d  = win;
`endif
                end
            end
            S_DRIVE: begin
                if (cnt_q == 8'd0) begin
                    seg_d   = adder_seg;
                    cout_d  = adder_cout;
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            gnt_q   <= 2'b00;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            seg_q   <= 7'h7F;
            cout_q  <= 1'b0;
`ifndef ADD_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            seg_q   <= seg_d;
            cout_q  <= cout_d;
`ifndef ADD_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_d;
    assign adder_a   = a_q;
    assign adder_b   = b_q;
    assign disp_seg  = seg_q;
    assign disp_cout = cout_q;

endmodule

// File: tb/tb_add_arb_ctrl.sv
// Self-checking bench for add_arb_ctrl: directed cases plus randomized
// transactions against a transaction-level arbitration model.
module tb_add_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] gnt, done;
    logic [3:0] adder_a, adder_b;
    logic [6:0] adder_seg;
    logic       adder_cout;
    logic [6:0] disp_seg;
    logic       disp_cout;

    int errors = 0;
    int checks = 0;
    int model_last;

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    logic [4:0] sum5;
    assign sum5       = {1'b0, adder_a} + {1'b0, adder_b};
    assign adder_seg  = seg7(sum5[3:0]);
    assign adder_cout = sum5[4];

    add_arb_ctrl #(.SETTLE(2), .HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .done(done),
        .adder_a(adder_a), .adder_b(adder_b),
        .adder_seg(adder_seg), .adder_cout(adder_cout),
        .disp_seg(disp_seg), .disp_cout(disp_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner chosen by the arbitration rule for the current req.
    function automatic int pick(input logic [1:0] r);
        int w;
        if (r == 2'b01) w = 0;
        else if (r == 2'b10) w = 1;
`ifdef ADD_ARB_FIXED_PRIO_EN
        else w = 0;
`else
        else w = (model_last == 1) ? 0 : 1;
`endif
        return w;
    endfunction

    // Called in the IDLE cycle T where req is sampled; returns in T+7.
    task automatic txn(input string tag, input int w, input logic [3:0] a,
                       input logic [3:0] b, input bit mutate);
        logic [4:0] s;
        logic [1:0] g;
        s = {1'b0, a} + {1'b0, b};
        g = (w == 1) ? 2'b10 : 2'b01;
        model_last = w;
        step();
        chk({tag, ".gnt1"}, gnt, g);
        chk({tag, ".a"}, adder_a, a);
        chk({tag, ".b"}, adder_b, b);
        chk({tag, ".done1"}, done, 2'b00);
        if (mutate) begin
            a0 = a0 + 4'd1; b0 = $urandom; a1 = a1 ^ 4'd6; b1 = $urandom;
            req = 2'b00;
        end
        step();
        chk({tag, ".gnt2"}, gnt, g);
        step();
        chk({tag, ".seg"}, disp_seg, seg7(s[3:0]));
        chk({tag, ".cout"}, disp_cout, s[4]);
        chk({tag, ".a3"}, adder_a, a);
        step();
        step();
        chk({tag, ".done5"}, done, 2'b00);
        step();
        chk({tag, ".done6"}, done, g);
        chk({tag, ".gnt6"}, gnt, g);
        step();
        chk({tag, ".gnt7"}, gnt, 2'b00);
        chk({tag, ".done7"}, done, 2'b00);
        chk({tag, ".seg7"}, disp_seg, seg7(s[3:0]));
    endtask

    initial begin
        int w;
        rst = 1'b1; req = 2'b00;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        model_last = 1;
        step();
        step();
        rst = 1'b0;
        chk("rst.gnt", gnt, 2'b00);
        chk("rst.done", done, 2'b00);
        chk("rst.seg", disp_seg, 7'h7F);
        chk("rst.cout", disp_cout, 1'b0);
        chk("rst.a", adder_a, 4'd0);
        chk("rst.b", adder_b, 4'd0);
        step();
        chk("idle.gnt", gnt, 2'b00);

        // Contention: both held for three transactions.
        req = 2'b11; a0 = 4'd1; b0 = 4'd2; a1 = 4'd6; b1 = 4'd7;
        for (int i = 0; i < 3; i++) begin
            w = pick(req);
            if (w == 0) txn("cont", 0, a0, b0, 1'b0);
            else txn("cont", 1, a1, b1, 1'b0);
        end
        req = 2'b00;
        step();

        req = 2'b01; a0 = 4'd3; b0 = 4'd4;
        txn("single", pick(req), 4'd3, 4'd4, 1'b0);
        chk("single.seg_is7", disp_seg, seg7(4'd7));

        req = 2'b10; a1 = 4'd9; b1 = 4'd9;
        txn("carry", pick(req), 4'd9, 4'd9, 1'b0);
        chk("carry.cout", disp_cout, 1'b1);

        req = 2'b01; a0 = 4'd5; b0 = 4'd5;
        txn("mut", pick(req), 4'd5, 4'd5, 1'b1);
        chk("mut.seg_isA", disp_seg, seg7(4'hA));

        // Reset in the middle of HOLD.
        req = 2'b01; a0 = 4'd2; b0 = 4'd3;
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_last = 1;
        chk("mrst.gnt", gnt, 2'b00);
        chk("mrst.done", done, 2'b00);
        chk("mrst.seg", disp_seg, 7'h7F);
        chk("mrst.cout", disp_cout, 1'b0);
        chk("mrst.a", adder_a, 4'd0);
        chk("mrst.b", adder_b, 4'd0);
        req = 2'b11; a1 = 4'd8; b1 = 4'd8;
        txn("post", pick(req), a0, b0, 1'b0);
        req = 2'b00;
        step();

        for (int i = 0; i < 40; i++) begin
            logic [3:0] ea, eb;
            req = 2'($urandom_range(1, 3));
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            w = pick(req);
            ea = (w == 1) ? a1 : a0;
            eb = (w == 1) ? b1 : b0;
            txn("rand", w, ea, eb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                req = 2'b00;
                step();
                chk("rand.idle", gnt, 2'b00);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
